// File: rtl/dmem_wbuf.sv
// Posted-store write buffer between the CPU data port and data memory.
// Stores drain in order through a request/ack port; loads forward from the youngest buffered store to the same word.
module dmem_wbuf #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_we,
    input  logic [31:0]            cpu_addr,
    input  logic [31:0]            cpu_wdata,
    output logic [31:0]            cpu_rdata,
    output logic                   stall,
    output logic                   mem_req,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    input  logic                   mem_ack,
    output logic [31:0]            mem_raddr,
    input  logic [31:0]            mem_rdata,
    output logic [$clog2(DEPTH):0] wb_count,
    output logic                   wb_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             full;
    logic             push;
    logic             pop;
    logic             fwd_hit;
    logic [31:0]      fwd_data;
    logic [PTR_W-1:0] idx;
    logic             unused_offset;

    assign full = (count == CNT_W'(DEPTH));
    assign push = cpu_we && !full;
    // An ack with nothing outstanding is meaningless and must not pop.
    assign pop  = (count != '0) && mem_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop)
                head <= head + PTR_W'(1);
            if (push)
                tail <= tail + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: validity comes from head/count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= cpu_addr[31:2];
            data_q[tail] <= cpu_wdata;
        end
    end

    // Walk entries oldest to youngest so the last match seen is the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (addr_q[idx] == cpu_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    assign stall     = cpu_we && full;
    assign mem_req   = (count != '0);
    assign mem_addr  = mem_req ? {addr_q[head], 2'b00} : 32'h0;
    assign mem_wdata = mem_req ? data_q[head] : 32'h0;
    assign mem_raddr = {cpu_addr[31:2], 2'b00};
    assign cpu_rdata = fwd_hit ? fwd_data : mem_rdata;
    assign wb_count  = count;
    assign wb_empty  = (count == '0);

    assign unused_offset = ^cpu_addr[1:0];

endmodule

// File: tb/tb_dmem_wbuf.sv
// Scoreboard bench for dmem_wbuf (DEPTH=4): queue model of buffered stores, per-cycle output checks, directed scenarios.
module tb_dmem_wbuf;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic [2:0]  wb_count;
    logic        wb_empty;

    typedef struct {
        logic [29:0] wa;
        logic [31:0] d;
    } entry_t;

    entry_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    dmem_wbuf #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .wb_count(wb_count), .wb_empty(wb_empty)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fake_mem(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    assign mem_rdata = fake_mem(mem_raddr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        logic [31:0] r;
        r = fake_mem({a[31:2], 2'b00});
        foreach (sb[i])
            if (sb[i].wa == a[31:2])
                r = sb[i].d;
        return r;
    endfunction

    // Per-cycle monitor: compare against the model, then apply this edge's pop/push.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            check("rst_req", {31'b0, mem_req}, 32'd0);
            check("rst_cnt", {29'b0, wb_count}, 32'd0);
            check("rst_empty", {31'b0, wb_empty}, 32'd1);
            check("rst_addr", mem_addr, 32'd0);
        end else begin
            logic push_ok;
            push_ok = cpu_we && (sb.size() < DEPTH);
            check("count", {29'b0, wb_count}, 32'(sb.size()));
            check("empty", {31'b0, wb_empty}, {31'b0, sb.size() == 0});
            check("req", {31'b0, mem_req}, {31'b0, sb.size() != 0});
            check("stall", {31'b0, stall}, {31'b0, cpu_we && sb.size() == DEPTH});
            check("raddr", mem_raddr, {cpu_addr[31:2], 2'b00});
            check("rdata", cpu_rdata, model_rdata(cpu_addr));
            if (sb.size() != 0) begin
                check("wr_addr", mem_addr, {sb[0].wa, 2'b00});
                check("wr_data", mem_wdata, sb[0].d);
                if (mem_ack)
                    void'(sb.pop_front());
            end else begin
                check("idle_addr", mem_addr, 32'd0);
                check("idle_data", mem_wdata, 32'd0);
            end
            if (push_ok)
                sb.push_back('{wa: cpu_addr[31:2], d: cpu_wdata});
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        cycle();
        cpu_we    = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        mem_ack = 1'b1;
        while (wb_count != 0 && k < 20) begin
            cycle();
            k++;
        end
        mem_ack = 1'b0;
        #1;
        check("drain_done", {31'b0, wb_empty}, 32'd1);
    endtask

    initial begin
        rst = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; mem_ack = 1'b0;
        #2;
        check("reset_stall", {31'b0, stall}, 32'd0);
        check("reset_empty", {31'b0, wb_empty}, 32'd1);
        cycle(); cycle();
        rst = 1'b1;
        cycle();

        // Single store then load of the same word; not forwarded in its own cycle.
        cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1111_1111;
        #1;
        check("no_same_cycle_fwd", cpu_rdata, fake_mem(32'h10));
        cycle();
        cpu_we = 1'b0;
        #1;
        check("fwd_a10", cpu_rdata, 32'h1111_1111);
        check("req_a10", {31'b0, mem_req}, 32'd1);
        check("addr_a10", mem_addr, 32'h10);
        drain();

        // Two stores to one word: youngest wins, offset ignored, drained in order.
        store(32'h20, 32'd1);
        store(32'h20, 32'd2);
        cpu_addr = 32'h22;
        #1;
        check("fwd_youngest", cpu_rdata, 32'd2);
        drain();

        // Fill to DEPTH, stall on the fifth, one ack lets it in.
        for (int i = 0; i < 5; i++) begin
            cpu_we = 1'b1; cpu_addr = 32'h40 + 32'(4 * i); cpu_wdata = 32'h100 + 32'(i);
            #1;
            if (i == 4) begin
                check("full_count", {29'b0, wb_count}, 32'd4);
                check("full_stall", {31'b0, stall}, 32'd1);
            end
            cycle();
        end
        mem_ack = 1'b1;
        cycle();
        mem_ack = 1'b0;
        #1;
        check("after_ack_stall", {31'b0, stall}, 32'd0);
        check("after_ack_count", {29'b0, wb_count}, 32'd3);
        cycle();
        cpu_we = 1'b0;
        #1;
        check("fifth_accepted", {29'b0, wb_count}, 32'd4);
        drain();

        // Ack while idle is ignored; push still lands.
        cpu_we = 1'b1; cpu_addr = 32'h60; cpu_wdata = 32'hCAFE_0001; mem_ack = 1'b1;
        cycle();
        cpu_we = 1'b0; mem_ack = 1'b0;
        #1;
        check("idle_ack_ignored", {29'b0, wb_count}, 32'd1);
        drain();

        // Simultaneous push/pop at count 2, then pointer wrap over 10 cycles.
        store(32'h80, 32'hA0);
        store(32'h84, 32'hA1);
        cpu_we = 1'b1; cpu_addr = 32'h88; cpu_wdata = 32'hA2; mem_ack = 1'b1;
        cycle();
        #1;
        check("pushpop_count", {29'b0, wb_count}, 32'd2);
        for (int i = 0; i < 10; i++) begin
            cpu_we = 1'b1; cpu_addr = 32'h100 + 32'(4 * i); cpu_wdata = $urandom; mem_ack = 1'b1;
            cycle();
        end
        cpu_we = 1'b0; mem_ack = 1'b0;
        #1;
        check("wrap_count", {29'b0, wb_count}, 32'd2);
        drain();

        // Reset mid-handshake with 3 entries pending.
        store(32'hC0, 32'hD0);
        store(32'hC4, 32'hD1);
        store(32'hC8, 32'hD2);
        cpu_addr = 32'hC4; mem_ack = 1'b1;
        #1;
        check("pre_rst_fwd", cpu_rdata, 32'hD1);
        rst = 1'b0;
        #1;
        check("rst_mid_req", {31'b0, mem_req}, 32'd0);
        check("rst_mid_count", {29'b0, wb_count}, 32'd0);
        cycle();
        rst = 1'b1; mem_ack = 1'b0;
        #1;
        check("post_rst_load", cpu_rdata, fake_mem(32'hC4));
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
